chunk_tx_arbiter: RTL and testbench
===================================

Name: chunk_tx_arbiter

Overview:
- Shares one chunk_serialize instance among N_SRC chunk-stream producers, e.g. filtered-image output, raw-image passthrough and debug/status stream.
- Grants are frame-atomic: a granted source keeps the serializer for exactly FRAME_CHUNKS accepted chunks before the grant moves on.
- Next grant is chosen round-robin among requesting sources.
- Sits between the filter pipeline outputs and chunk_serialize's axis_i.

Parameters:
- N_SRC, 3, number of requesting chunk streams (2..8)
- FRAME_CHUNKS, 64, chunks per frame; the grant is held for this many output handshakes (>=1)
- CNT_W, $clog2(FRAME_CHUNKS+1), beat-counter width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  allow new grants; when low, an in-progress frame still completes
- axis_i[N_SRC]  axis_if slave  pixel_pkg::chunk_t  source streams (data/vld/rdy)
- axis_o  axis_if master  pixel_pkg::chunk_t  to chunk_serialize axis_i
- grant_o  out  $clog2(N_SRC)  index of the source currently owning the output
- busy_o  out  1  high while in BURST
- frames_o  out  16  count of completed frames, wraps at 2^16

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-low.
- Reset (rst=0): state=IDLE, rr_ptr=0, grant_o=0, beat_cnt=0, frames_o=0, busy_o=0, axis_o.vld=0, all axis_i[k].rdy=0.
- States: IDLE, BURST.
- IDLE transition:
  - if en && any axis_i[k].vld: pick the first requesting index at or after rr_ptr, modulo N_SRC.
  - Register the pick into grant_o, clear beat_cnt, go to BURST next cycle.
  - Arbitration latency is 1 cycle; no data passes in IDLE.
- IDLE outputs: axis_o.vld=0 and all rdy=0.
- BURST datapath:
  - Purely combinational: axis_o.data = axis_i[grant_o].data, axis_o.vld = axis_i[grant_o].vld, axis_i[grant_o].rdy = axis_o.rdy.
  - Every other source sees rdy=0.
  - No added latency; no buffering.
- BURST counting: beat_cnt increments only on axis_o.vld && axis_o.rdy. A source dropping vld mid-frame stalls the output; the grant is not released.
- Frame end: when beat_cnt==FRAME_CHUNKS-1 and a handshake occurs:
  - go to IDLE, rr_ptr = grant_o+1 (wrap to 0 at N_SRC), frames_o += 1.
  - The next frame's grant is issued no earlier than the following cycle, so there is a 1-cycle bubble between frames.
- en deasserted during BURST: no effect until the frame ends; then the block stays in IDLE while en=0.
- Simultaneous requests: only the round-robin pick is granted; others wait with rdy=0 and must hold vld/data (AXI-stream rule).
- FRAME_CHUNKS=1: each handshake ends the burst; rotation still occurs.
- Reset mid-BURST: immediate return to reset values. Any partial frame is abandoned; downstream resynchronisation is the system's concern.
- grant_o is stable throughout BURST and holds its last value in IDLE.
- busy_o is a registered decode of state.

Decomposition:
- pixel_pkg gains typedef arb_state_t {IDLE, BURST} and localparam FRAME_CHUNKS_DEFAULT.
- One combinational sub-module: rr_pick, parameter N. Inputs: req[N], ptr. Outputs: idx, any. Implemented as double-width masked priority encode.
- The mux and counter live in chunk_tx_arbiter.

Test Plan:
- Bench setup for all scenarios: N_SRC=2, FRAME_CHUNKS=4, axis_o.rdy=1 unless stated.
- Reset: rst=0 with sources driving vld=1 -> axis_o.vld=0, all rdy=0, frames_o=0, grant_o=0. After release, first handshake occurs on the 2nd cycle.
- Single source: src1 sends chunks 0xA0..0xA3 -> axis_o shows 0xA0..0xA3 on 4 consecutive cycles; grant_o=1; frames_o=1; src0 rdy stays 0.
- Contention: both sources vld continuously -> output frames alternate src0, src1, src0. Each frame is exactly 4 beats, with a 1-cycle vld=0 bubble between frames.
- Backpressure and gaps: axis_o.rdy toggles 1,0,1,0 and src0 drops vld for 3 cycles mid-frame -> still exactly 4 beats transferred, no duplicates, grant not released early.
- en=0 after beat 2 of a frame -> frame completes (4 beats), then no new grant while en=0. Re-asserting en grants the next source in round-robin order.
- Mid-burst reset: assert rst after beat 2 -> outputs return to reset values within the same cycle, frames_o unchanged at 0, rr_ptr=0.

Source files
------------

// File: rtl/pixel_pkg.sv
// pixel_pkg: shared types for the chunk streaming path.
//   chunk_t              - one chunk word carried on axis_if
//   arb_state_t          - chunk_tx_arbiter state encoding (IDLE / BURST)
//   FRAME_CHUNKS_DEFAULT - default number of chunks in one frame
package pixel_pkg;

    typedef logic [31:0] chunk_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int FRAME_CHUNKS_DEFAULT = 64;

endpackage

// File: rtl/axis_if.sv
// axis_if: minimal valid/ready stream carrying one chunk_t per beat.
//   data - chunk payload (master -> slave)
//   vld  - payload valid  (master -> slave)
//   rdy  - slave can accept (slave -> master)
interface axis_if;
    import pixel_pkg::*;

    chunk_t data;
    logic   vld;
    logic   rdy;

    modport master (output data, output vld, input rdy);
    modport slave  (input data, input vld, output rdy);

endinterface

// File: rtl/chunk_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req - request vector, one bit per source
//   ptr - index with highest priority this round (must be < N)
//   idx - first requesting index at or after ptr, wrapping modulo N
//   any - at least one request is present
// The request vector is doubled so the wrap-around search becomes a single
// linear priority encode over bits [ptr .. ptr+N-1].
module rr_pick #(
    parameter int N = 3
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int IW = $clog2(N);

    logic [2*N-1:0] dbl_s;

    // Masked priority encode over the doubled request vector.
    always_comb begin
        dbl_s = {req, req};
        idx   = '0;
        any   = |req;
        // Scan downwards so the lowest qualifying bit is the final winner.
        for (int i = 2 * N - 1; i >= 0; i--) begin
            idx = (dbl_s[i] && (i >= int'(ptr))) ? IW'(i % N) : idx;
        end
    end

endmodule

// File: rtl/chunk_tx_arbiter.sv
// chunk_tx_arbiter: shares one chunk serializer among N_SRC chunk streams.
// A granted source owns the output for exactly FRAME_CHUNKS handshakes;
// the next owner is chosen round-robin one cycle after the frame ends.
//   clk      - system clock
//   rst      - asynchronous active-low reset
//   en       - allow new grants (a frame in progress always completes)
//   axis_i   - source streams (slave side)
//   axis_o   - output stream to the serializer (master side)
//   grant_o  - index of the source owning the output
//   busy_o   - high while a frame is in progress
//   frames_o - completed frame count, wraps at 2^16
module chunk_tx_arbiter
    import pixel_pkg::*;
#(
    parameter int N_SRC        = 3,
    parameter int FRAME_CHUNKS = FRAME_CHUNKS_DEFAULT,
    parameter int CNT_W        = $clog2(FRAME_CHUNKS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    axis_if.slave                    axis_i [N_SRC],
    axis_if.master                   axis_o,
    output logic [$clog2(N_SRC)-1:0] grant_o,
    output logic                     busy_o,
    output logic [15:0]              frames_o
);

    localparam int GW = $clog2(N_SRC);

    arb_state_t       state_r;
    logic [GW-1:0]    rr_ptr_r;
    logic [GW-1:0]    grant_r;
    logic [CNT_W-1:0] beat_cnt_r;
    logic [15:0]      frames_r;
    logic             busy_r;

    logic [N_SRC-1:0] vld_s;
    chunk_t           data_s [N_SRC];
    logic [N_SRC-1:0] rdy_s;
    logic             sel_vld_s;
    chunk_t           sel_data_s;
    logic             out_vld_s;
    logic             out_rdy_s;
    logic             hs_s;
    logic             last_beat_s;
    logic [GW-1:0]    rr_next_s;
    logic [GW-1:0]    pick_idx_s;
    logic             pick_any_s;

    // Flatten the interface array so the mux can use a run-time index.
    for (genvar k = 0; k < N_SRC; k++) begin : g_src
        assign vld_s[k]      = axis_i[k].vld;
        assign data_s[k]     = axis_i[k].data;
        assign axis_i[k].rdy = rdy_s[k];
    end

    assign out_rdy_s   = axis_o.rdy;
    assign axis_o.vld  = out_vld_s;
    assign axis_o.data = sel_data_s;

    rr_pick #(
        .N (N_SRC)
    ) u_rr_pick (
        .req (vld_s),
        .ptr (rr_ptr_r),
        .idx (pick_idx_s),
        .any (pick_any_s)
    );

    // Zero-latency path from the granted source to the output; ready only
    // reaches the owner, and only while a frame is in progress.
    always_comb begin
        sel_vld_s  = 1'b0;
        sel_data_s = '0;
        rdy_s      = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (grant_r == GW'(k)) begin
                sel_vld_s  = vld_s[k];
                sel_data_s = data_s[k];
                rdy_s[k]   = (state_r == BURST) ? out_rdy_s : 1'b0;
            end else begin
                rdy_s[k] = 1'b0;
            end
        end
        out_vld_s = (state_r == BURST) ? sel_vld_s : 1'b0;
    end

    assign hs_s        = out_vld_s && out_rdy_s;
    assign last_beat_s = (beat_cnt_r == CNT_W'(FRAME_CHUNKS - 1));
    assign rr_next_s   = (grant_r == GW'(N_SRC - 1)) ? '0 : grant_r + GW'(1);

    // Arbitration FSM with beat counter, frame counter and registered status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            rr_ptr_r   <= '0;
            grant_r    <= '0;
            beat_cnt_r <= '0;
            frames_r   <= 16'd0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (en && pick_any_s) begin
                        grant_r    <= pick_idx_s;
                        beat_cnt_r <= '0;
                        state_r    <= BURST;
                        busy_r     <= 1'b1;
                    end
                end
                BURST: begin
                    // Stalls (vld or rdy low) simply hold the count; the
                    // grant is only released by the final handshake.
                    if (hs_s) begin
                        if (last_beat_s) begin
                            state_r    <= IDLE;
                            busy_r     <= 1'b0;
                            beat_cnt_r <= '0;
                            rr_ptr_r   <= rr_next_s;
                            frames_r   <= frames_r + 16'd1;
                        end else begin
                            beat_cnt_r <= beat_cnt_r + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign grant_o  = grant_r;
    assign busy_o   = busy_r;
    assign frames_o = frames_r;

endmodule

// File: tb/tb_chunk_tx_arbiter.sv
// tb_chunk_tx_arbiter: scoreboard bench for chunk_tx_arbiter (2 sources,
// 4-chunk frames). Source drivers push every chunk they offer into a
// per-source expected queue; a monitor tracks frame ownership with a
// frame-level reference model and pops/compares on every output beat.
module tb_chunk_tx_arbiter;

    localparam int NS = 2;
    localparam int FC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b1;
    logic [1:0]  src_vld = 2'b00;
    logic [31:0] src_data [NS];
    logic [1:0]  src_rdy;
    logic        out_rdy = 1'b1;
    logic [0:0]  grant_o;
    logic        busy_o;
    logic [15:0] frames_o;

    axis_if src_if [NS] ();
    axis_if out_if ();

    for (genvar g = 0; g < NS; g++) begin : g_src
        assign src_if[g].vld  = src_vld[g];
        assign src_if[g].data = src_data[g];
        assign src_rdy[g]     = src_if[g].rdy;
    end
    assign out_if.rdy = out_rdy;

    chunk_tx_arbiter #(.N_SRC(NS), .FRAME_CHUNKS(FC)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .axis_i   (src_if),
        .axis_o   (out_if),
        .grant_o  (grant_o),
        .busy_o   (busy_o),
        .frames_o (frames_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // stimulus controls
    int          remaining [NS];
    logic [31:0] nd [NS];
    int          gap [NS];
    bit          rand_data = 1'b0;
    bit          gap_en    = 1'b0;
    bit          en_rand   = 1'b0;
    int          rdy_mode  = 0;
    logic [31:0] exp_q [NS][$];

    // reference model state (the cycle ahead of the upcoming edge)
    bit          m_busy   = 1'b0;
    int          m_grant  = 0;
    int          m_beats  = 0;
    int          m_ptr    = 0;
    logic [15:0] m_frames = 16'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // first requesting source at or after the round-robin pointer
    function automatic int rr_choice(input logic [1:0] req, input int ptr);
        int r = 0;
        for (int i = NS - 1; i >= 0; i--) begin
            if (req[(ptr + i) % NS]) r = (ptr + i) % NS;
        end
        return r;
    endfunction

    // source drivers + output ready + optional random enable
    initial begin
        bit took [NS];
        for (int s = 0; s < NS; s++) begin
            remaining[s] = 0; nd[s] = 32'd0; gap[s] = 0; src_data[s] = 32'd0;
        end
        forever begin
            @(negedge clk);
            for (int s = 0; s < NS; s++) took[s] = src_vld[s] && src_rdy[s];
            @(posedge clk);
            #1;
            for (int s = 0; s < NS; s++) begin
                if (took[s]) begin
                    src_vld[s] = 1'b0;
                    if (gap_en && $urandom_range(0, 2) == 0) gap[s] = 3;
                end
                if (!src_vld[s]) begin
                    if (gap[s] > 0) gap[s]--;
                    else if (remaining[s] > 0) begin
                        src_data[s] = nd[s];
                        exp_q[s].push_back(nd[s]);
                        src_vld[s] = 1'b1;
                        remaining[s]--;
                        nd[s] = rand_data ? $urandom : nd[s] + 32'd1;
                    end
                end
            end
            case (rdy_mode)
                0: out_rdy = 1'b1;
                1: out_rdy = ~out_rdy;
                default: out_rdy = ($urandom_range(0, 3) != 0);
            endcase
            if (en_rand) en = ($urandom_range(0, 7) != 0);
        end
    end

    // monitor: compare DUT against the model, then advance the model
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rst_busy", busy_o, 1'b0);
                chk("rst_grant", grant_o, 1'b0);
                chk("rst_frames", frames_o, 16'd0);
                chk("rst_out_vld", out_if.vld, 1'b0);
                chk("rst_rdy", src_rdy, 2'b00);
                m_busy = 1'b0; m_grant = 0; m_beats = 0; m_ptr = 0; m_frames = 16'd0;
            end else begin
                chk("busy", busy_o, m_busy);
                chk("grant", grant_o, m_grant);
                chk("frames", frames_o, m_frames);
                if (m_busy) begin
                    chk("out_vld", out_if.vld, src_vld[m_grant]);
                    chk("rdy_owner", src_rdy[m_grant], out_rdy);
                    chk("rdy_other", src_rdy[1 - m_grant], 1'b0);
                    if (src_vld[m_grant] && out_rdy) begin
                        if (exp_q[m_grant].size() == 0) begin
                            chk("data_queue_nonempty", 32'd0, 32'd1);
                        end else begin
                            chk("data", out_if.data, exp_q[m_grant].pop_front());
                        end
                        m_beats++;
                        if (m_beats == FC) begin
                            m_busy = 1'b0; m_beats = 0;
                            m_ptr = (m_grant + 1) % NS;
                            m_frames = m_frames + 16'd1;
                        end
                    end
                end else begin
                    chk("idle_out_vld", out_if.vld, 1'b0);
                    chk("idle_rdy", src_rdy, 2'b00);
                    if (en && (src_vld != 2'b00)) begin
                        m_grant = rr_choice(src_vld, m_ptr);
                        m_busy = 1'b1; m_beats = 0;
                    end
                end
            end
        end
    end

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (!(remaining[0] == 0 && remaining[1] == 0 && src_vld == 2'b00 && !m_busy)
               && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL timeout_%s actual=%0d cycles required<%0d", tag, n, budget);
        end
    endtask

    task automatic wait_beats(input int beats, input int budget, input string tag);
        int n = 0;
        while (!(m_busy && m_beats >= beats) && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL timeout_%s actual=%0d cycles required<%0d", tag, n, budget);
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
        #2;
    endtask

    task automatic at_pos();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // reset with src1 already offering 0xA0..0xA3
        nd[1] = 32'hA0;
        remaining[1] = 4;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        wait_idle(100, "single");
        chk("single_frames", frames_o, 16'd1);
        chk("single_grant", grant_o, 1'b1);

        // contention: src0, src1, src0
        at_neg();
        nd[0] = 32'h100; nd[1] = 32'h200;
        remaining[0] = 8; remaining[1] = 4;
        wait_idle(200, "contention");
        chk("contention_frames", frames_o, 16'd4);

        // backpressure toggling and source gaps
        at_neg();
        rdy_mode = 1; gap_en = 1'b1; nd[0] = 32'h300;
        remaining[0] = 4;
        wait_idle(300, "backpressure");
        chk("bp_frames", frames_o, 16'd5);

        // enable dropped mid-frame
        at_neg();
        rdy_mode = 0; gap_en = 1'b0; nd[0] = 32'h400; nd[1] = 32'h500;
        remaining[0] = 4; remaining[1] = 4;
        wait_beats(2, 100, "en_beats");
        at_pos();
        en = 1'b0;
        repeat (12) @(posedge clk);
        chk("en_hold_busy", busy_o, 1'b0);
        chk("en_hold_frames", frames_o, 16'd6);
        at_pos();
        en = 1'b1;
        wait_idle(200, "en_resume");
        chk("en_frames", frames_o, 16'd7);

        // randomized traffic
        at_neg();
        rand_data = 1'b1; gap_en = 1'b1; rdy_mode = 2; en_rand = 1'b1;
        remaining[0] = 20; remaining[1] = 20;
        wait_idle(3000, "random");
        at_pos();
        en_rand = 1'b0; en = 1'b1;
        for (int s = 0; s < NS; s++) chk("drain", exp_q[s].size(), 32'd0);

        // reset in the middle of a burst
        at_neg();
        rand_data = 1'b0; gap_en = 1'b0; rdy_mode = 0;
        nd[0] = 32'h600; remaining[0] = 4;
        wait_beats(2, 100, "rst_beats");
        at_pos();
        rst = 1'b0;
        #1;
        chk("midrst_busy", busy_o, 1'b0);
        chk("midrst_out_vld", out_if.vld, 1'b0);
        chk("midrst_rdy", src_rdy, 2'b00);
        chk("midrst_grant", grant_o, 1'b0);
        chk("midrst_frames", frames_o, 16'd0);
        at_neg();
        // finish the abandoned frame from scratch, with src1 also competing
        remaining[0] = 4 - int'(src_vld[0]);
        nd[1] = 32'h700; remaining[1] = 4;
        at_pos();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 chk("midrst_first_grant", grant_o, 1'b0);
        wait_idle(200, "post_reset");
        chk("post_reset_frames", frames_o, 16'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
